piece_collide_chk: RTL

//  Sequential collision checker sitting directly downstream of the piece-shape selector.
//  - Takes a 4x4 piece mask (16 bits, row-major, bit 0 = top-left) plus a board position.
//  - Reads the four covered board rows, one per cycle, from the playfield row RAM.
//  - Reports whether placing the piece there would overlap a wall, the floor or settled cells.
//  - Used by the game controller before committing any move, rotation or drop.

---
 rtl/piece_collide_chk.sv | 98 +++++++++
 1 files changed

// File: rtl/piece_collide_chk.sv
// piece_collide_chk: checks a 4x4 piece mask at a board position against the walls, the floor and the settled cells.
module piece_collide_chk #(
   parameter int BOARD_W = 10,
   parameter int BOARD_H = 20,
   parameter int ROW_AW  = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [0:15]        block,
   input  logic [4:0]         pos_x,
   input  logic [5:0]         pos_y,
   output logic               rd_en,
   output logic [ROW_AW-1:0]  row_addr,
   input  logic [BOARD_W-1:0] row_data,
   output logic               busy,
   output logic               done,
   output logic               collide,
   output logic               hit_wall,
   output logic               hit_floor,
   output logic               hit_stack
);
   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;
   localparam logic [BOARD_W-1:0] ONE_W = {{(BOARD_W-1){1'b0}}, 1'b1};
   state_t             state_q, state_d;
   logic [1:0]         r_q;
   logic [0:15]        block_q;
   logic [4:0]         px_q;
   logic [5:0]         py_q;
   logic [BOARD_W-1:0] pend_q, row_m;
   logic [6:0]         row;
   logic               row_ok, accept, wall_now, row_any;
   // next state, handshake outputs and the read request for the current mask row
   always_comb begin
      accept   = start && (state_q == S_IDLE || state_q == S_DONE);
      state_d  = accept ? S_READ :
                 (state_q == S_READ) ? ((r_q == 2'd3) ? S_DRAIN : S_READ) :
                 (state_q == S_DRAIN) ? S_DONE : S_IDLE;
      busy     = state_q == S_READ || state_q == S_DRAIN;
      done     = state_q == S_DONE;
      row      = {1'b0, py_q} + {5'd0, r_q};
      row_ok   = row < 7'(BOARD_H);
      rd_en    = state_q == S_READ && row_ok;
      row_addr = rd_en ? row[ROW_AW-1:0] : '0;
   end
   // project mask row r onto board columns; off-board cells flag the wall instead
   always_comb begin
      logic [5:0] col;
      logic       bit_set, col_ok;
      row_m    = '0;
      wall_now = 1'b0;
      row_any  = 1'b0;
      col      = '0;
      bit_set  = 1'b0;
      col_ok   = 1'b0;
      for (int c = 0; c < 4; c++) begin
         col      = {px_q[4], px_q} + 6'(c);
         bit_set  = block_q[{r_q, 2'(c)}];
         col_ok   = !col[5] && col < 6'(BOARD_W);
         row_any  = row_any | bit_set;
         wall_now = wall_now | (bit_set && !col_ok);
         row_m    = row_m | ((bit_set && col_ok) ? (ONE_W << col) : '0);
      end
   end
   // capture on accept, then sweep rows and merge returning RAM data one cycle behind
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         r_q       <= '0;
         block_q   <= '0;
         px_q      <= '0;
         py_q      <= '0;
         pend_q    <= '0;
         hit_wall  <= 1'b0;
         hit_floor <= 1'b0;
         hit_stack <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            r_q       <= '0;
            block_q   <= block;
            px_q      <= pos_x;
            py_q      <= pos_y;
            pend_q    <= '0;
            hit_wall  <= 1'b0;
            hit_floor <= 1'b0;
            hit_stack <= 1'b0;
         end else begin
            r_q       <= (state_q == S_READ) ? r_q + 2'd1 : r_q;
            pend_q    <= (state_q == S_READ && row_ok) ? row_m : '0;
            hit_wall  <= hit_wall | (state_q == S_READ && wall_now);
            hit_floor <= hit_floor | (state_q == S_READ && !row_ok && row_any);
            hit_stack <= hit_stack | (|(pend_q & row_data));
         end
      end
   end
   assign collide = hit_wall | hit_floor | hit_stack;
endmodule
